uart_ascii_pos_rx: RTL and testbench

Receive side of the ultrasonic-position serial link: recovers 8N1 UART bytes from `rx`, then parses ASCII records of the form axis letter, 1–3 decimal digits, terminator (e.g. "X123\r") into binary centimetre values. It sits at the far end of the distance transmitter path and feeds `position_x`/`position_y` of the VGA display block, replacing the locally measured sensor values on a remote board.

---
 rtl/uart_ascii_pos_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_ascii_pos_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ascii_pos_rx.sv
// rtl/uart_ascii_pos_rx.sv - 8N1 UART receiver plus "X123\r" ASCII position record parser
// Optional build macro UART_RX_PARITY_EN selects 8E1 framing with an even-parity check.
module uart_ascii_pos_rx #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rx_byte_valid,
   output logic [7:0] distance_X_cm,
   output logic [7:0] distance_Y_cm,
   output logic       update_X,
   output logic       update_Y,
   output logic       frame_err,
   output logic       parse_err
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] L_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] L_HALF = CW'(DIV / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } byte_state_t;

   typedef enum logic [1:0] {P_WAIT_AXIS, P_WAIT_DIGIT, P_DIGITS} parse_state_t;

   logic          r_rx_s1, r_rx_s2;
   byte_state_t   r_bstate;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx_byte;
   logic          r_rx_byte_valid;
   logic          r_frame_err;
   logic          r_par_err;

   parse_state_t  r_pstate;
   logic          r_axis_y;
   logic [9:0]    r_acc;
   logic [1:0]    r_count;
   logic [7:0]    r_dist_x, r_dist_y;
   logic          r_update_x, r_update_y, r_parse_err;

   logic          w_stop_tick, w_frame_bad;
   logic          w_is_digit, w_is_x, w_is_y, w_is_term;
   logic [3:0]    w_digit;
   logic [7:0]    w_sat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

   assign w_stop_tick = (r_bstate == S_STOP) && (r_cnt == L_FULL);
   assign w_frame_bad = w_stop_tick && (!r_rx_s2 || r_par_err);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bstate        <= S_IDLE;
         r_cnt           <= '0;
         r_bitcnt        <= '0;
         r_shift         <= '0;
         r_rx_byte       <= '0;
         r_rx_byte_valid <= 1'b0;
         r_frame_err     <= 1'b0;
         r_par_err       <= 1'b0;
      end else begin
         r_rx_byte_valid <= 1'b0;
         r_frame_err     <= 1'b0;
         case (r_bstate)
            S_IDLE: begin
               r_par_err <= 1'b0;
               if (!r_rx_s2) begin
                  r_bstate <= S_START;
                  r_cnt    <= '0;
                  r_bitcnt <= '0;
               end
            end
            S_START: begin
               if (r_cnt == L_HALF) begin
                  r_cnt    <= '0;
                  r_bstate <= r_rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == L_FULL) begin
                  r_cnt    <= '0;
                  r_shift  <= {r_rx_s2, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (r_bitcnt == 3'd7) r_bstate <= S_PARITY;
`else
                  if (r_bitcnt == 3'd7) r_bstate <= S_STOP;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == L_FULL) begin
                  r_cnt     <= '0;
                  r_par_err <= ^{r_shift, r_rx_s2};
                  r_bstate  <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == L_FULL) begin
                  // Back to IDLE mid-stop-bit so a back-to-back start edge is not missed
                  r_cnt    <= '0;
                  r_bstate <= S_IDLE;
                  if (w_frame_bad) begin
                     r_frame_err <= 1'b1;
                  end else begin
                     r_rx_byte       <= r_shift;
                     r_rx_byte_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_bstate <= S_IDLE;
         endcase
      end
   end

   assign w_is_digit = (r_rx_byte >= 8'h30) && (r_rx_byte <= 8'h39);
   assign w_digit    = r_rx_byte[3:0];
   assign w_is_x     = (r_rx_byte == 8'h58) || (r_rx_byte == 8'h78);
   assign w_is_y     = (r_rx_byte == 8'h59) || (r_rx_byte == 8'h79);
   assign w_is_term  = (r_rx_byte == 8'h0D) || (r_rx_byte == 8'h0A);
   assign w_sat      = (r_acc > 10'd255) ? 8'hFF : r_acc[7:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pstate    <= P_WAIT_AXIS;
         r_axis_y    <= 1'b0;
         r_acc       <= '0;
         r_count     <= '0;
         r_dist_x    <= '0;
         r_dist_y    <= '0;
         r_update_x  <= 1'b0;
         r_update_y  <= 1'b0;
         r_parse_err <= 1'b0;
      end else begin
         r_update_x  <= 1'b0;
         r_update_y  <= 1'b0;
         r_parse_err <= 1'b0;
         if (w_frame_bad) begin
            if (r_pstate != P_WAIT_AXIS) r_parse_err <= 1'b1;
            r_pstate <= P_WAIT_AXIS;
         end else if (r_rx_byte_valid) begin
            case (r_pstate)
               P_WAIT_AXIS: begin
                  if (w_is_x || w_is_y) begin
                     r_axis_y <= w_is_y;
                     r_acc    <= '0;
                     r_pstate <= P_WAIT_DIGIT;
                  end
               end
               P_WAIT_DIGIT: begin
                  if (w_is_digit) begin
                     r_acc    <= {6'd0, w_digit};
                     r_count  <= 2'd1;
                     r_pstate <= P_DIGITS;
                  end else begin
                     r_parse_err <= 1'b1;
                     r_pstate    <= P_WAIT_AXIS;
                  end
               end
               P_DIGITS: begin
                  if (w_is_digit && r_count < 2'd3) begin
                     r_acc   <= r_acc * 10'd10 + {6'd0, w_digit};
                     r_count <= r_count + 1'b1;
                  end else if (w_is_term) begin
                     if (r_axis_y) begin
                        r_dist_y   <= w_sat;
                        r_update_y <= 1'b1;
                     end else begin
                        r_dist_x   <= w_sat;
                        r_update_x <= 1'b1;
                     end
                     r_pstate <= P_WAIT_AXIS;
                  end else if (w_is_x || w_is_y) begin
                     // Unterminated record, but the letter still opens a fresh one
                     r_parse_err <= 1'b1;
                     r_axis_y    <= w_is_y;
                     r_acc       <= '0;
                     r_pstate    <= P_WAIT_DIGIT;
                  end else begin
                     r_parse_err <= 1'b1;
                     r_pstate    <= P_WAIT_AXIS;
                  end
               end
               default: r_pstate <= P_WAIT_AXIS;
            endcase
         end
      end
   end

   assign rx_byte       = r_rx_byte;
   assign rx_byte_valid = r_rx_byte_valid;
   assign frame_err     = r_frame_err;
   assign distance_X_cm = r_dist_x;
   assign distance_Y_cm = r_dist_y;
   assign update_X      = r_update_x;
   assign update_Y      = r_update_y;
   assign parse_err     = r_parse_err;

endmodule

// File: tb/tb_uart_ascii_pos_rx.sv
// tb/tb_uart_ascii_pos_rx.sv - directed bench for uart_ascii_pos_rx (DIV = 16)
// Honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_ascii_pos_rx;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 100_000;
   localparam int DIV    = CLK_HZ / BAUD;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic [7:0] distance_X_cm, distance_Y_cm;
   logic       update_X, update_Y, frame_err, parse_err;

   uart_ascii_pos_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx            (rx),
      .rx_byte       (rx_byte),
      .rx_byte_valid (rx_byte_valid),
      .distance_X_cm (distance_X_cm),
      .distance_Y_cm (distance_Y_cm),
      .update_X      (update_X),
      .update_Y      (update_Y),
      .frame_err     (frame_err),
      .parse_err     (parse_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_valid = 0, n_updx = 0, n_updy = 0, n_perr = 0, n_ferr = 0, n_both = 0;
   int t_valid = 0, upd_lag = -1, perr_lag = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_byte_valid) begin
         n_valid <= n_valid + 1;
         t_valid <= cyc;
      end
      if (update_X) begin
         n_updx  <= n_updx + 1;
         upd_lag <= cyc - t_valid;
      end
      if (update_Y) n_updy <= n_updy + 1;
      if (parse_err) begin
         n_perr   <= n_perr + 1;
         perr_lag <= cyc - t_valid;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
      if (frame_err && parse_err) n_both <= n_both + 1;
   end

   int n_vec = 0, n_miss = 0;
   int s_valid, s_updx, s_updy, s_perr, s_ferr, s_both;
   int t_start;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_valid = n_valid; s_updx = n_updx; s_updy = n_updy;
      s_perr  = n_perr;  s_ferr = n_ferr; s_both = n_both;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
      @(negedge clk);
      t_start = cyc;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      repeat (DIV) @(negedge clk);
`else
      if (par_flip) rx = 1'b1;
`endif
      rx = stop;
      repeat (DIV - 1) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_x", distance_X_cm, 0);
      check("reset_y", distance_Y_cm, 0);
      check("reset_byte", rx_byte, 0);
      check("reset_pulses", {rx_byte_valid, update_X, update_Y, frame_err, parse_err}, 0);
      reset_n = 1'b1;
      repeat (2 * DIV) @(posedge clk);

      snap();
      send_byte("X", 1'b1, 1'b0);
      settle();
`ifdef UART_RX_PARITY_EN
      check("valid_latency", ((t_valid - t_start) >= 170 && (t_valid - t_start) <= 172) ? 1 : 0, 1);
`else
      check("valid_latency", ((t_valid - t_start) >= 154 && (t_valid - t_start) <= 156) ? 1 : 0, 1);
`endif
      send_str("123\r");
      settle();
      check("x123_x", distance_X_cm, 123);
      check("x123_y", distance_Y_cm, 0);
      check("x123_updx", n_updx - s_updx, 1);
      check("x123_errs", (n_perr - s_perr) + (n_ferr - s_ferr), 0);
      check("x123_lastbyte", rx_byte, 8'h0D);
      check("commit_lag", upd_lag, 1);

      snap();
      send_str("Y7\n");
      settle();
      check("y7", distance_Y_cm, 7);
      send_str("y045\r\n");
      settle();
      check("y45", distance_Y_cm, 45);
      check("y_updy", n_updy - s_updy, 2);
      check("y_bytes", n_valid - s_valid, 9);
      check("y_perr", n_perr - s_perr, 0);

      snap();
      send_str("X999\r");
      settle();
      check("x999_sat", distance_X_cm, 255);
      send_str("X1234\r");
      settle();
      check("x1234_perr", n_perr - s_perr, 1);
      check("x1234_x", distance_X_cm, 255);
      check("x1234_updx", n_updx - s_updx, 1);

      snap();
      send_byte(8'h58, 1'b0, 1'b0);
      repeat (2 * DIV) @(posedge clk);
      #1;
      check("stop_low_ferr", n_ferr - s_ferr, 1);
      check("stop_low_valid", n_valid - s_valid, 0);
      send_str("X5\r");
      settle();
      check("x5", distance_X_cm, 5);

      snap();
      send_str("X1");
      send_byte("2", 1'b0, 1'b0);
      repeat (2 * DIV) @(posedge clk);
      send_str("\r");
      settle();
      check("abort_ferr", n_ferr - s_ferr, 1);
      check("abort_perr_same", n_both - s_both, 1);
      check("abort_x", distance_X_cm, 5);

      snap();
      send_str("X4Y8\r");
      settle();
      check("restart_perr", n_perr - s_perr, 1);
      check("perr_lag", perr_lag, 1);
      check("restart_y", distance_Y_cm, 8);
      check("restart_x", distance_X_cm, 5);

      snap();
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(posedge clk);
      #1;
      check("glitch_valid", n_valid - s_valid, 0);
      check("glitch_ferr", n_ferr - s_ferr, 0);

      send_str("X1");
      snap();
      @(negedge clk);
      rx = 1'b0;
      repeat (DIV + DIV / 2) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_x", distance_X_cm, 0);
      check("rst_y", distance_Y_cm, 0);
      check("rst_byte", rx_byte, 0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2 * DIV) @(posedge clk);
      #1;
      check("rst_no_pulses", (n_valid - s_valid) + (n_updx - s_updx) + (n_perr - s_perr) + (n_ferr - s_ferr), 0);
      send_str("Y9\r");
      settle();
      check("post_rst_y", distance_Y_cm, 9);
      check("post_rst_x", distance_X_cm, 0);

`ifdef UART_RX_PARITY_EN
      snap();
      send_byte(8'h58, 1'b1, 1'b1);
      repeat (2 * DIV) @(posedge clk);
      #1;
      check("par_bad_ferr", n_ferr - s_ferr, 1);
      check("par_bad_valid", n_valid - s_valid, 0);
      send_byte(8'h58, 1'b1, 1'b0);
      settle();
      check("par_ok_byte", rx_byte, 8'h58);
      check("par_ok_valid", n_valid - s_valid, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
